// File: rtl/itr_sequencer_if.sv
// Bus between the interrupt sequencer and its surroundings (MHVPIS handler and CPU control unit).
// Handshake: instr_done is a one-cycle strobe marking an instruction boundary; i_pending and reti
// are only acted on in a cycle where instr_done is high; pc_load, ctx_load, bad_reti and
// isr_timeout are one-cycle strobes; itr_clr, itr_en, cpu_stall and in_isr are levels.
interface itr_sequencer_if #(
  parameter int ADDR_W = 8,
  parameter int ACC_W  = 8
);
  logic              i_pending;
  logic [ADDR_W-1:0] isr_addr;
  logic              instr_done;
  logic              reti;
  logic [ADDR_W-1:0] pc_in;
  logic [ACC_W-1:0]  acc_in;
  logic [1:0]        flags_in;

  logic              cpu_stall;
  logic              pc_load;
  logic [ADDR_W-1:0] pc_load_val;
  logic              ctx_load;
  logic [ACC_W-1:0]  acc_load_val;
  logic [1:0]        flags_load_val;
  logic              itr_clr;
  logic              itr_en;
  logic              in_isr;
  logic              bad_reti;
  logic              isr_timeout;
  logic [2:0]        dbg_state;

  modport master (
    output i_pending, isr_addr, instr_done, reti, pc_in, acc_in, flags_in,
    input  cpu_stall, pc_load, pc_load_val, ctx_load, acc_load_val, flags_load_val,
           itr_clr, itr_en, in_isr, bad_reti, isr_timeout, dbg_state
  );

  modport slave (
    input  i_pending, isr_addr, instr_done, reti, pc_in, acc_in, flags_in,
    output cpu_stall, pc_load, pc_load_val, ctx_load, acc_load_val, flags_load_val,
           itr_clr, itr_en, in_isr, bad_reti, isr_timeout, dbg_state
  );
endinterface

// File: rtl/itr_sequencer.sv
// Single-level interrupt entry/exit sequencer: saves context, vectors to the ISR, restores on
// RETI, and forces an exit from an ISR that runs too many instructions.
module itr_sequencer #(
  parameter int ADDR_W      = 8,
  parameter int ACC_W       = 8,
  parameter int ISR_TIMEOUT = 64
) (
  input  logic clk,
  input  logic clr,
  itr_sequencer_if.slave bus
);

  localparam int WDOG_W = (ISR_TIMEOUT > 0) ? $clog2(ISR_TIMEOUT + 1) : 1;
  localparam logic [WDOG_W-1:0] WDOG_MAX = WDOG_W'(ISR_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SAVE    = 3'd1,
    S_VEC     = 3'd2,
    S_ISR     = 3'd3,
    S_RESTORE = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [ADDR_W-1:0] r_saved_pc;
  logic [ACC_W-1:0]  r_saved_acc;
  logic [1:0]        r_saved_flags;
  logic [ADDR_W-1:0] r_vec_q;
  logic [WDOG_W-1:0] r_wdog_cnt;
  logic              r_bad_reti;
  logic              r_isr_timeout;

  logic [WDOG_W-1:0] w_wdog_inc;
  logic              w_wdog_hit;
  logic              w_accept;
  logic              w_isr_exit;
  logic              w_itr_clr;
  logic              w_itr_en;
  logic              w_stall;
  logic              w_pc_load;
  logic [ADDR_W-1:0] w_pc_load_val;
  logic              w_ctx_load;
  logic              w_in_isr;

  assign w_wdog_inc = r_wdog_cnt + WDOG_W'(1);
  assign w_wdog_hit = (ISR_TIMEOUT != 0) && (w_wdog_inc == WDOG_MAX);
  assign w_accept   = (r_state == S_IDLE) && bus.instr_done && bus.i_pending;
  assign w_isr_exit = (r_state == S_ISR) && bus.instr_done && (bus.reti || w_wdog_hit);

  always_ff @(posedge clk) begin
    if (clr) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state  = r_state;
    w_itr_clr     = 1'b0;
    w_itr_en      = 1'b0;
    w_stall       = 1'b0;
    w_pc_load     = 1'b0;
    w_pc_load_val = '0;
    w_ctx_load    = 1'b0;
    w_in_isr      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_itr_en = 1'b1;
        if (w_accept) w_next_state = S_SAVE;
      end
      S_SAVE: begin
        w_itr_clr    = 1'b1;
        w_stall      = 1'b1;
        w_next_state = S_VEC;
      end
      S_VEC: begin
        w_pc_load     = 1'b1;
        w_pc_load_val = r_vec_q;
        w_stall       = 1'b1;
        w_next_state  = S_ISR;
      end
      S_ISR: begin
        w_in_isr = 1'b1;
        if (w_isr_exit) w_next_state = S_RESTORE;
      end
      S_RESTORE: begin
        w_pc_load     = 1'b1;
        w_pc_load_val = r_saved_pc;
        w_ctx_load    = 1'b1;
        w_stall       = 1'b1;
        w_next_state  = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Context and vector are frozen at acceptance; the watchdog counts only ISR boundaries.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_saved_pc    <= '0;
      r_saved_acc   <= '0;
      r_saved_flags <= '0;
      r_vec_q       <= '0;
      r_wdog_cnt    <= '0;
      r_bad_reti    <= 1'b0;
      r_isr_timeout <= 1'b0;
    end else begin
      if (w_accept) begin
        r_saved_pc    <= bus.pc_in;
        r_saved_acc   <= bus.acc_in;
        r_saved_flags <= bus.flags_in;
        r_vec_q       <= bus.isr_addr;
      end
      r_bad_reti    <= (r_state == S_IDLE) && bus.instr_done && bus.reti;
      r_isr_timeout <= w_isr_exit && !bus.reti;
      if (w_isr_exit) begin
        r_wdog_cnt <= '0;
      end else if ((r_state == S_ISR) && bus.instr_done && (r_wdog_cnt != WDOG_MAX)) begin
        r_wdog_cnt <= w_wdog_inc;
      end
    end
  end

  // Reset flushes the handler at once and suppresses any in-flight load.
  assign bus.itr_clr        = w_itr_clr | clr;
  assign bus.pc_load        = w_pc_load & ~clr;
  assign bus.ctx_load       = w_ctx_load & ~clr;
  assign bus.pc_load_val    = w_pc_load_val;
  assign bus.itr_en         = w_itr_en;
  assign bus.cpu_stall      = w_stall;
  assign bus.in_isr         = w_in_isr;
  assign bus.acc_load_val   = r_saved_acc;
  assign bus.flags_load_val = r_saved_flags;
  assign bus.bad_reti       = r_bad_reti;
  assign bus.isr_timeout    = r_isr_timeout;
  assign bus.dbg_state      = r_state;

endmodule

// File: tb/tb_itr_sequencer.sv
// Bench for itr_sequencer: directed scenarios with literal expectations, then random traffic,
// all checked every cycle against a transaction-level model of entry/ISR/return.
module tb_itr_sequencer;

  localparam int TIMEOUT = 4;

  logic clk = 1'b0;
  logic clr;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  itr_sequencer_if #(.ADDR_W(8), .ACC_W(8)) bus ();

  itr_sequencer #(.ADDR_W(8), .ACC_W(8), .ISR_TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus.slave)
  );

  // Model: entry step (0 none, 1 save cycle, 2 vector cycle), ISR flag, return flag.
  int         m_entry;
  bit         m_in_isr;
  bit         m_restore;
  int         m_cnt;
  logic [7:0] m_pc, m_acc, m_vec;
  logic [1:0] m_flags;
  bit         m_bad, m_to;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit nb, nt, idle;
    nb = 0;
    nt = 0;
    if (clr) begin
      m_entry = 0; m_in_isr = 0; m_restore = 0; m_cnt = 0;
      m_pc = '0; m_acc = '0; m_vec = '0; m_flags = '0;
    end else begin
      idle = (m_entry == 0) && !m_in_isr && !m_restore;
      if (m_entry == 1) m_entry = 2;
      else if (m_entry == 2) begin m_entry = 0; m_in_isr = 1; end
      else if (m_restore) m_restore = 0;
      else if (m_in_isr) begin
        if (bus.instr_done) begin
          m_cnt++;
          if (bus.reti || (TIMEOUT != 0 && m_cnt == TIMEOUT)) begin
            nt = !bus.reti;
            m_in_isr = 0; m_restore = 1; m_cnt = 0;
          end
        end
      end else if (idle) begin
        nb = bus.instr_done && bus.reti;
        if (bus.instr_done && bus.i_pending) begin
          m_pc = bus.pc_in; m_acc = bus.acc_in; m_flags = bus.flags_in; m_vec = bus.isr_addr;
          m_entry = 1;
        end
      end
    end
    m_bad = clr ? 1'b0 : nb;
    m_to  = clr ? 1'b0 : nt;
  endtask

  task automatic compare_all();
    bit idle;
    logic [7:0] exp_val;
    idle    = (m_entry == 0) && !m_in_isr && !m_restore;
    exp_val = (m_entry == 2) ? m_vec : (m_restore ? m_pc : 8'h00);
    check("itr_clr",     bus.itr_clr,     clr | (m_entry == 1));
    check("itr_en",      bus.itr_en,      idle);
    check("cpu_stall",   bus.cpu_stall,   (m_entry != 0) || m_restore);
    check("pc_load",     bus.pc_load,     !clr && ((m_entry == 2) || m_restore));
    check("pc_load_val", bus.pc_load_val, exp_val);
    check("ctx_load",    bus.ctx_load,    !clr && m_restore);
    check("acc_val",     bus.acc_load_val,   m_acc);
    check("flags_val",   bus.flags_load_val, m_flags);
    check("in_isr",      bus.in_isr,      m_in_isr);
    check("bad_reti",    bus.bad_reti,    m_bad);
    check("isr_timeout", bus.isr_timeout, m_to);
  endtask

  task automatic drive(input bit c, input bit p, input logic [7:0] a, input bit d, input bit r,
                       input logic [7:0] pc, input logic [7:0] acc, input logic [1:0] f);
    clr            = c;
    bus.i_pending  = p;
    bus.isr_addr   = a;
    bus.instr_done = d;
    bus.reti       = r;
    bus.pc_in      = pc;
    bus.acc_in     = acc;
    bus.flags_in   = f;
  endtask

  // Drive at the falling edge, clock, then compare after outputs settle.
  task automatic cycle(input bit c, input bit p, input logic [7:0] a, input bit d, input bit r,
                       input logic [7:0] pc, input logic [7:0] acc, input logic [1:0] f);
    drive(c, p, a, d, r, pc, acc, f);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle_cycle(input bit p, input bit d);
    cycle(0, p, 8'h00, d, 0, 8'h00, 8'h00, 2'b00);
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    cycle(1, 0, 8'h00, 0, 0, 8'h00, 8'h00, 2'b00);
    check("rst_itr_clr", bus.itr_clr, 1'b1);
    idle_cycle(0, 0);
    check("rst_itr_en", bus.itr_en, 1'b1);
    check("rst_pc_load", bus.pc_load, 1'b0);

    // Basic entry, vector freeze and no nesting.
    cycle(0, 1, 8'h96, 1, 0, 8'h23, 8'h5A, 2'b01);
    check("ent_itr_clr", bus.itr_clr, 1'b1);
    check("ent_itr_en", bus.itr_en, 1'b0);
    cycle(0, 1, 8'hD7, 0, 0, 8'h24, 8'h00, 2'b10);
    check("ent_pc_load", bus.pc_load, 1'b1);
    check("ent_vec", bus.pc_load_val, 8'h96);
    cycle(0, 1, 8'hD7, 0, 0, 8'h24, 8'h00, 2'b10);
    check("ent_in_isr", bus.in_isr, 1'b1);
    cycle(0, 1, 8'hD7, 1, 0, 8'h97, 8'h11, 2'b11);
    check("nest_itr_clr", bus.itr_clr, 1'b0);
    check("nest_in_isr", bus.in_isr, 1'b1);

    // Return restores the context captured at entry.
    cycle(0, 0, 8'hD7, 1, 1, 8'h98, 8'h22, 2'b10);
    check("ret_pc_load", bus.pc_load, 1'b1);
    check("ret_pc", bus.pc_load_val, 8'h23);
    check("ret_ctx", bus.ctx_load, 1'b1);
    check("ret_acc", bus.acc_load_val, 8'h5A);
    check("ret_flags", bus.flags_load_val, 2'b01);
    idle_cycle(0, 0);
    check("ret_itr_en", bus.itr_en, 1'b1);

    // Stray RETI outside an ISR.
    cycle(0, 0, 8'h00, 1, 1, 8'h30, 8'h00, 2'b00);
    check("stray_pulse", bus.bad_reti, 1'b1);
    check("stray_no_load", bus.pc_load, 1'b0);
    idle_cycle(0, 0);
    check("stray_pulse_end", bus.bad_reti, 1'b0);
    check("stray_idle", bus.itr_en, 1'b1);

    // Watchdog: four boundaries without RETI force the exit.
    cycle(0, 1, 8'h10, 1, 0, 8'h40, 8'h77, 2'b10);
    idle_cycle(0, 0);
    idle_cycle(0, 0);
    for (int i = 0; i < 3; i++) idle_cycle(0, 1);
    check("wd_still_isr", bus.in_isr, 1'b1);
    idle_cycle(0, 1);
    check("wd_pulse", bus.isr_timeout, 1'b1);
    check("wd_pc", bus.pc_load_val, 8'h40);
    check("wd_load", bus.pc_load, 1'b1);
    idle_cycle(0, 0);
    check("wd_pulse_end", bus.isr_timeout, 1'b0);

    // RETI on the fourth boundary is a normal exit.
    cycle(0, 1, 8'h20, 1, 0, 8'h50, 8'h66, 2'b01);
    idle_cycle(0, 0);
    idle_cycle(0, 0);
    for (int i = 0; i < 3; i++) idle_cycle(0, 1);
    cycle(0, 0, 8'h00, 1, 1, 8'h00, 8'h00, 2'b00);
    check("wdr_no_pulse", bus.isr_timeout, 1'b0);
    check("wdr_ctx", bus.ctx_load, 1'b1);
    check("wdr_pc", bus.pc_load_val, 8'h50);
    idle_cycle(0, 0);

    // Reset while the vector load is being presented.
    cycle(0, 1, 8'h55, 1, 0, 8'h77, 8'h33, 2'b11);
    idle_cycle(0, 0);
    clr = 1'b1;
    #1;
    check("mid_no_load", bus.pc_load, 1'b0);
    check("mid_itr_clr", bus.itr_clr, 1'b1);
    cycle(1, 0, 8'h00, 0, 0, 8'h00, 8'h00, 2'b00);
    idle_cycle(0, 0);
    check("mid_idle", bus.itr_en, 1'b1);
    check("mid_acc0", bus.acc_load_val, 8'h00);
    check("mid_flags0", bus.flags_load_val, 2'b00);
    check("mid_no_isr", bus.in_isr, 1'b0);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      bit d;
      d = ($urandom_range(99) < 40);
      cycle(($urandom_range(199) == 0),
            ($urandom_range(99) < 30),
            8'($urandom_range(255)),
            d,
            d && ($urandom_range(99) < 30),
            8'($urandom_range(255)),
            8'($urandom_range(255)),
            2'($urandom_range(3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/itr_sequencer.md
Name: itr_sequencer

Overview:
- Interrupt entry/exit sequencer directly downstream of the MHVPIS priority interrupt handler.
- Consumes `i_pending` and the ISR vector (`PC_out`) from the handler, and takes interrupts only at instruction boundaries.
- On entry: saves PC/ACC/flags, clears the handler, and loads the ISR address into the PC. On RETI: restores the saved context.
- Single-level: no nesting. An ISR watchdog forces exit from runaway ISRs.

Parameters:
- ADDR_W, 8, PC/ISR address width
- ACC_W, 8, accumulator width
- ISR_TIMEOUT, 64, max instr_done pulses inside an ISR before forced exit; 0 disables the watchdog

Ports:
- clk  in  1  system clock, rising edge
- clr  in  1  synchronous active-high reset
- i_pending  in  1  pending interrupt from MHVPIS
- isr_addr  in  ADDR_W  ISR vector from MHVPIS PC_out
- instr_done  in  1  one-cycle pulse at instruction boundary from control unit
- reti  in  1  current instruction is RETI; qualified by instr_done
- pc_in  in  ADDR_W  address of next instruction
- acc_in  in  ACC_W  accumulator value
- flags_in  in  2  {V,Z} ALU flags
- cpu_stall  out  1  freeze fetch/execute
- pc_load  out  1  one-cycle PC load strobe
- pc_load_val  out  ADDR_W  PC load value
- ctx_load  out  1  one-cycle ACC+flags restore strobe
- acc_load_val  out  ACC_W  saved ACC
- flags_load_val  out  2  saved flags
- itr_clr  out  1  clear to MHVPIS interrupt/mask registers
- itr_en  out  1  enable to MHVPIS
- in_isr  out  1  executing ISR
- bad_reti  out  1  one-cycle pulse: RETI outside ISR
- isr_timeout  out  1  one-cycle pulse: watchdog forced exit

Behaviour:
- FSM states:
  - IDLE: itr_en=1.
  - SAVE: itr_clr=1, itr_en=0, cpu_stall=1.
  - VEC: pc_load=1, pc_load_val=vec_q, itr_en=0, cpu_stall=1.
  - ISR: in_isr=1, itr_en=0.
  - RESTORE: pc_load=1, pc_load_val=saved_pc, ctx_load=1, itr_en=0, cpu_stall=1.
- All FSM outputs are decoded from the registered state; bad_reti and isr_timeout are registered pulses.
- Reset (clr=1 at a clk edge):
  - state=IDLE; saved_pc, saved_acc, saved_flags, vec_q and wdog_cnt all 0; bad_reti=0, isr_timeout=0.
  - itr_clr is forced high combinationally while clr=1, flushing MHVPIS.
  - Reset mid-sequence (any state) aborts to IDLE with no pc_load or ctx_load issued.
- IDLE with instr_done=1 and i_pending=1 → SAVE. On that edge, capture saved_pc←pc_in, saved_acc←acc_in, saved_flags←flags_in, vec_q←isr_addr. The vector is frozen at acceptance; later isr_addr changes are ignored.
- IDLE with instr_done=1, reti=1 → bad_reti pulses 1 cycle; RETI is treated as a NOP. If i_pending is also 1, entry is still taken the same edge.
- IDLE with i_pending=1 but no instr_done → wait; no action.
- SAVE → VEC → ISR, unconditional, one cycle each. Entry latency from the accepting edge to pc_load is 2 cycles.
- ISR:
  - i_pending is ignored (no nesting).
  - Each instr_done increments wdog_cnt; wdog_cnt saturates at ISR_TIMEOUT.
  - instr_done with reti=1 → RESTORE.
  - If ISR_TIMEOUT≠0 and instr_done without reti would make wdog_cnt reach ISR_TIMEOUT → RESTORE, with isr_timeout pulsing on the same edge.
  - RETI on the same instr_done as the timeout counts as a normal exit; no isr_timeout pulse.
- RESTORE → IDLE after one cycle. wdog_cnt clears on RESTORE entry. Exit latency from the RETI edge to pc_load is 1 cycle.
- An interrupt pending on return is taken no earlier than the first instr_done seen in IDLE (≥1 instruction executes after RESTORE only if instr_done is not coincident).
- Widths: wdog_cnt is clog2(ISR_TIMEOUT+1) bits, minimum 1. No arithmetic beyond the increment.

Test Plan:
- Basic entry: i_pending=1, isr_addr=8'h96, pc_in=8'h23, acc_in=8'h5A, flags_in=2'b01 with instr_done → itr_clr high 1 cycle; pc_load=1 with pc_load_val=8'h96 two cycles after acceptance; in_isr=1; itr_en=0.
- Return: in ISR, instr_done+reti → next cycle pc_load=1 pc_load_val=8'h23, ctx_load=1, acc_load_val=8'h5A, flags_load_val=2'b01; then IDLE with itr_en=1.
- Vector freeze / no nesting: change isr_addr to 8'hD7 during SAVE, keep i_pending=1 in ISR → pc_load_val stays 8'h96; no re-entry until after RESTORE.
- Stray RETI: IDLE, instr_done+reti, i_pending=0 → bad_reti one-cycle pulse, no pc_load, state stays IDLE.
- Watchdog with ISR_TIMEOUT=4: four instr_done pulses without reti → isr_timeout pulse, RESTORE with pc_load_val=saved_pc. With RETI on the 4th pulse → no isr_timeout.
- Reset mid-sequence: assert clr during VEC → no pc_load, itr_clr=1 while clr is high, state IDLE, all saved registers 0.
